// File: rtl/qupls4_cmp_arb_pkg.sv
// Shared types for the qupls4 compare arbiter: compare opcodes, condition-byte
// bit positions and the S1/S2 pipeline stage records.
package qupls4_cmp_arb_pkg;

  localparam int CMP_WID  = 64;
  localparam int CMP_TAGW = 8;
  localparam int PORTW    = 3;

  typedef enum logic [1:0] {
    CMP   = 2'd0,
    CMPU  = 2'd1,
    CMPI  = 2'd2,
    CMPUI = 2'd3
  } cmp_op_e;

  localparam int CB_EQ = 0;
  localparam int CB_NE = 1;
  localparam int CB_LT = 2;
  localparam int CB_LE = 3;
  localparam int CB_GT = 4;
  localparam int CB_GE = 5;

  // S1 keeps only the second operand actually used: b for register forms, i for immediates.
  typedef struct packed {
    cmp_op_e               op;
    logic [CMP_WID-1:0]    a;
    logic [CMP_WID-1:0]    b;
    logic [CMP_TAGW-1:0]   tag;
    logic [PORTW-1:0]      port;
  } s1_t;

  typedef struct packed {
    logic [7:0]            cb;
    logic [CMP_TAGW-1:0]   tag;
    logic [PORTW-1:0]      port;
  } s2_t;

  function automatic logic is_unsigned_op(cmp_op_e op);
    return (op == CMPU) || (op == CMPUI);
  endfunction

  function automatic logic is_imm_op(cmp_op_e op);
    return (op == CMPI) || (op == CMPUI);
  endfunction

endpackage

// File: rtl/qupls4_rr_pick.sv
// Combinational round-robin picker: searches req starting one past ptr and
// returns the first hit as a one-hot grant (gated by en) and its index.
module qupls4_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    if (en && found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/qupls4_cmp_arb.sv
// Shared integer compare unit: round-robin arbitration over NREQ issue ports,
// two-stage pipeline, condition-byte result. Optional QUPLS4_CMP_ARB_PERF_EN adds counters.
module qupls4_cmp_arb
  import qupls4_cmp_arb_pkg::*;
#(
  parameter int WID  = CMP_WID,
  parameter int NREQ = 4,
  parameter int TAGW = CMP_TAGW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*2-1:0]    req_op,
  input  logic [NREQ*WID-1:0]  req_a,
  input  logic [NREQ*WID-1:0]  req_b,
  input  logic [NREQ*WID-1:0]  req_i,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_cb,
  output logic [TAGW-1:0]      res_tag,
  output logic [2:0]           res_port
`ifdef QUPLS4_CMP_ARB_PERF_EN
  ,
  output logic [31:0]          perf_grants,
  output logic [31:0]          perf_stalls
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshakes: a transfer happens in any cycle where valid and ready are both high;
  // ready never depends on anything but pipeline room, flush/rst and the pick.
  logic          s1_v, s2_v;
  s1_t           s1_q, s1_d;
  s2_t           s2_q;
  logic [PW-1:0] ptr;
  logic          s1_take, s2_take, pick_en, hs;
  logic [NREQ-1:0] grant;
  logic [PW-1:0] gidx;

  assign s2_take = s1_v & (~s2_v | res_ready);
  assign s1_take = ~s1_v | s2_take;
  assign pick_en = s1_take & ~flush & ~rst;

  qupls4_rr_pick #(
    .N  (NREQ),
    .IW (PW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (pick_en),
    .grant (grant),
    .idx   (gidx)
  );

  assign req_ready = grant;
  assign hs        = |grant;

  // Operand capture for the granted port.
  cmp_op_e         sel_op;
  logic [WID-1:0]  sel_a, sel_b, sel_i;
  logic [TAGW-1:0] sel_tag;

  always_comb begin
    sel_op  = cmp_op_e'(req_op[int'(gidx)*2 +: 2]);
    sel_a   = req_a[int'(gidx)*WID +: WID];
    sel_b   = req_b[int'(gidx)*WID +: WID];
    sel_i   = req_i[int'(gidx)*WID +: WID];
    sel_tag = req_tag[int'(gidx)*TAGW +: TAGW];
    s1_d      = '0;
    s1_d.op   = sel_op;
    s1_d.a    = sel_a;
    s1_d.b    = is_imm_op(sel_op) ? sel_i : sel_b;
    s1_d.tag  = sel_tag;
    s1_d.port = PORTW'(gidx);
  end

  // Comparator is purely combinational off the S1 register.
  logic       c_uns, c_eq, c_lt;
  logic [7:0] cb;

  always_comb begin
    c_uns = is_unsigned_op(s1_q.op);
    c_eq  = (s1_q.a == s1_q.b);
    c_lt  = c_uns ? (s1_q.a < s1_q.b) : ($signed(s1_q.a) < $signed(s1_q.b));
    cb        = '0;
    cb[CB_EQ] = c_eq;
    cb[CB_NE] = ~c_eq;
    cb[CB_LT] = c_lt;
    cb[CB_LE] = c_lt | c_eq;
    cb[CB_GT] = ~(c_lt | c_eq);
    cb[CB_GE] = ~c_lt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_q <= '0;
      s2_v <= 1'b0;
      s2_q <= '0;
      ptr  <= PW'(NREQ - 1);
    end else begin
      if (hs) begin
        s1_q <= s1_d;
        ptr  <= gidx;
      end
      if (flush)        s1_v <= 1'b0;
      else if (s1_take) s1_v <= hs;

      if (s2_take) s2_q <= '{cb: cb, tag: s1_q.tag, port: s1_q.port};
      // A result handshaken during flush is already delivered, so clearing is safe.
      if (flush)          s2_v <= 1'b0;
      else if (s2_take)   s2_v <= 1'b1;
      else if (res_ready) s2_v <= 1'b0;
    end
  end

  assign res_valid = s2_v;
  assign res_cb    = s2_q.cb;
  assign res_tag   = s2_q.tag;
  assign res_port  = s2_q.port;

`ifdef QUPLS4_CMP_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      if (hs)                 perf_grants <= perf_grants + 32'd1;
      if (s2_v & ~res_ready)  perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
